// File: rtl/bios_host_pkg.sv
// Shared types and character constants for the BIOS console host side.
package bios_host_pkg;

   // Lower-case keyword characters
   localparam logic [6:0] ASCII_LC_A = 7'h61;
   localparam logic [6:0] ASCII_LC_B = 7'h62;
   localparam logic [6:0] ASCII_LC_D = 7'h64;
   localparam logic [6:0] ASCII_LC_E = 7'h65;
   localparam logic [6:0] ASCII_LC_I = 7'h69;
   localparam logic [6:0] ASCII_LC_N = 7'h6E;
   localparam logic [6:0] ASCII_LC_O = 7'h6F;
   localparam logic [6:0] ASCII_LC_P = 7'h70;
   localparam logic [6:0] ASCII_LC_R = 7'h72;
   localparam logic [6:0] ASCII_LC_S = 7'h73;
   localparam logic [6:0] ASCII_LC_T = 7'h74;
   localparam logic [6:0] ASCII_LC_W = 7'h77;

   // Reply characters produced by the BIOS
   localparam logic [6:0] BIOS_ACK_NOP       = 7'h4E; // 'N'
   localparam logic [6:0] BIOS_ACK_BOOT      = 7'h42; // 'B'
   localparam logic [6:0] BIOS_ACK_RST       = 7'h52; // 'R'
   localparam logic [6:0] BIOS_ACK_WRITE     = 7'h57; // 'W'
   localparam logic [6:0] BIOS_ACK_READ      = 7'h52; // 'R'
   localparam logic [6:0] BIOS_ERR_BADCMD    = 7'h45; // 'E'
   localparam logic [6:0] BIOS_ERR_UNKNOWN   = 7'h30; // '0'
   localparam logic [6:0] BIOS_ERR_EXCEPTION = 7'h58; // 'X'

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_BOOT  = 3'd1,
      OP_RST   = 3'd2,
      OP_WRITE = 3'd3,
      OP_READ  = 3'd4
   } bios_op_t;

   typedef enum logic [2:0] {
      ST_OK         = 3'd0,
      ST_BADCMD     = 3'd1,
      ST_UNKNOWN    = 3'd2,
      ST_EXCEPTION  = 3'd3,
      ST_UNEXPECTED = 3'd4,
      ST_TIMEOUT    = 3'd5,
      ST_BADOP      = 3'd6
   } bios_host_status_t;

   // Acknowledge character the BIOS returns for a successful command
   function automatic logic [6:0] bios_ack_char(input logic [2:0] op);
      logic [6:0] ack;
      ack = 7'h00;
      case (op)
         OP_NOP:   ack = BIOS_ACK_NOP;
         OP_BOOT:  ack = BIOS_ACK_BOOT;
         OP_RST:   ack = BIOS_ACK_RST;
         OP_WRITE: ack = BIOS_ACK_WRITE;
         OP_READ:  ack = BIOS_ACK_READ;
         default:  ack = 7'h00;
      endcase
      return ack;
   endfunction

   // Map a reply character to a transaction status; the ack check comes first
   function automatic bios_host_status_t bios_classify(input logic [2:0] op, input logic [6:0] ch);
      bios_host_status_t st;
      if (ch == bios_ack_char(op))        st = ST_OK;
      else if (ch == BIOS_ERR_BADCMD)     st = ST_BADCMD;
      else if (ch == BIOS_ERR_UNKNOWN)    st = ST_UNKNOWN;
      else if (ch == BIOS_ERR_EXCEPTION)  st = ST_EXCEPTION;
      else                                st = ST_UNEXPECTED;
      return st;
   endfunction

endpackage

// File: rtl/bios_host_kw_rom.sv
// Keyword table: (opcode, char index) -> keyword character and last-char flag.
module bios_kw_rom
   import bios_host_pkg::*;
(
   input  logic [2:0] op,
   input  logic [2:0] idx,
   output logic [6:0] kw_char,
   output logic       last
);

   logic [2:0] kw_len;

   // Table lookup; unknown opcodes read as a single zero character
   always_comb begin
      kw_char = 7'h00;
      kw_len  = 3'd1;
      case (op)
         OP_NOP: begin
            kw_len = 3'd3;
            case (idx)
               3'd0:    kw_char = ASCII_LC_N;
               3'd1:    kw_char = ASCII_LC_O;
               default: kw_char = ASCII_LC_P;
            endcase
         end
         OP_BOOT: begin
            kw_len = 3'd4;
            case (idx)
               3'd0:    kw_char = ASCII_LC_B;
               3'd1:    kw_char = ASCII_LC_O;
               3'd2:    kw_char = ASCII_LC_O;
               default: kw_char = ASCII_LC_T;
            endcase
         end
         OP_RST: begin
            kw_len = 3'd3;
            case (idx)
               3'd0:    kw_char = ASCII_LC_R;
               3'd1:    kw_char = ASCII_LC_S;
               default: kw_char = ASCII_LC_T;
            endcase
         end
         OP_WRITE: begin
            kw_len = 3'd5;
            case (idx)
               3'd0:    kw_char = ASCII_LC_W;
               3'd1:    kw_char = ASCII_LC_R;
               3'd2:    kw_char = ASCII_LC_I;
               3'd3:    kw_char = ASCII_LC_T;
               default: kw_char = ASCII_LC_E;
            endcase
         end
         OP_READ: begin
            kw_len = 3'd4;
            case (idx)
               3'd0:    kw_char = ASCII_LC_R;
               3'd1:    kw_char = ASCII_LC_E;
               3'd2:    kw_char = ASCII_LC_A;
               default: kw_char = ASCII_LC_D;
            endcase
         end
         default: begin
            kw_len  = 3'd1;
            kw_char = 7'h00;
         end
      endcase
      last = (idx == kw_len - 3'd1);
   end

endmodule

// File: rtl/bios_host.sv
// Command initiator: sends an opcode's keyword to the BIOS, waits for and classifies the reply.
module bios_host
   import bios_host_pkg::*;
#(
   parameter int DATA_W         = 7,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              clk_en,
   input  logic              rst,
   input  logic [2:0]        cmd_op,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_out_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_in_ready,
   output logic              done,
   output logic [2:0]        status,
   output logic [DATA_W-1:0] rsp_char
);

   localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   typedef logic [1:0] host_state_t;
   localparam host_state_t S_IDLE = 2'd0;
   localparam host_state_t S_SEND = 2'd1;
   localparam host_state_t S_WAIT = 2'd2;
   localparam host_state_t S_DONE = 2'd3;

   host_state_t        state_reg, state_next;
   logic [2:0]         op_reg, op_next;
   logic [2:0]         idx_reg, idx_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   bios_host_status_t  status_reg, status_next;
   logic [DATA_W-1:0]  rsp_reg, rsp_next;
   logic               last_reg;
   logic               cmd_ready_reg, o_valid_reg, o_in_ready_reg, done_reg;
   logic [DATA_W-1:0]  o_data_reg;
   logic [6:0]         rom_char;
   logic               rom_last;

   // Lookup is addressed with the next op/index so o_data and the last flag are registered
   bios_kw_rom u_kw_rom (
      .op      (op_next),
      .idx     (idx_next),
      .kw_char (rom_char),
      .last    (rom_last)
   );

   // Next-state and datapath decisions for one enabled cycle
   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      idx_next    = idx_reg;
      timer_next  = timer_reg;
      status_next = status_reg;
      rsp_next    = rsp_reg;
      case (state_reg)
         S_IDLE: begin
            // Stray reply characters are accepted here and simply dropped
            if (cmd_valid) begin
               op_next  = cmd_op;
               idx_next = 3'd0;
               if (cmd_op > 3'd4) begin
                  state_next  = S_DONE;
                  status_next = ST_BADOP;
                  rsp_next    = '0;
               end else begin
                  state_next = S_SEND;
               end
            end
         end
         S_SEND: begin
            if (i_out_ready) begin
               idx_next = idx_reg + 3'd1;
               if (last_reg) begin
                  state_next = S_WAIT;
                  timer_next = '0;
               end
            end
         end
         S_WAIT: begin
            // A reply on the final timer cycle still wins over the timeout
            if (i_valid) begin
               rsp_next    = i_data;
               status_next = bios_classify(op_reg, i_data[6:0]);
               state_next  = S_DONE;
            end else if (timer_reg == TIMER_LAST) begin
               rsp_next    = '0;
               status_next = ST_TIMEOUT;
               state_next  = S_DONE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over clk_en, clk_en gates everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         op_reg         <= 3'd0;
         idx_reg        <= 3'd0;
         timer_reg      <= '0;
         status_reg     <= ST_OK;
         rsp_reg        <= '0;
         last_reg       <= 1'b0;
         cmd_ready_reg  <= 1'b1;
         o_valid_reg    <= 1'b0;
         o_data_reg     <= '0;
         o_in_ready_reg <= 1'b1;
         done_reg       <= 1'b0;
      end else if (clk_en) begin
         state_reg      <= state_next;
         op_reg         <= op_next;
         idx_reg        <= idx_next;
         timer_reg      <= timer_next;
         status_reg     <= status_next;
         rsp_reg        <= rsp_next;
         last_reg       <= rom_last;
         cmd_ready_reg  <= (state_next == S_IDLE);
         o_valid_reg    <= (state_next == S_SEND);
         o_data_reg     <= (state_next == S_SEND) ? DATA_W'(rom_char) : '0;
         o_in_ready_reg <= (state_next == S_IDLE) || (state_next == S_WAIT);
         done_reg       <= (state_next == S_DONE);
      end
   end

   assign cmd_ready  = cmd_ready_reg;
   assign o_valid    = o_valid_reg;
   assign o_data     = o_data_reg;
   assign o_in_ready = o_in_ready_reg;
   assign done       = done_reg;
   assign status     = status_reg;
   assign rsp_char   = rsp_reg;

endmodule

// File: tb/tb_bios_host.sv
// Self-checking bench for bios_host: directed scenarios plus randomized command traffic.
module tb_bios_host;

   localparam int DW = 7;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          clk_en, rst, cmd_valid, cmd_ready, o_valid, i_out_ready, i_valid, o_in_ready, done;
   logic [2:0]    cmd_op, status;
   logic [DW-1:0] o_data, i_data, rsp_char;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   string kw_tab [5] = '{"nop", "boot", "rst", "write", "read"};
   string ack_tab = "NBRWR";

   bios_host #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .clk_en(clk_en), .rst(rst), .cmd_op(cmd_op), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
      .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready), .done(done),
      .status(status), .rsp_char(rsp_char)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Reference: keyword length, expected status and reply char straight from the command rules
   function automatic int exp_len(input int op);
      return (op > 4) ? 0 : kw_tab[op].len();
   endfunction

   function automatic int exp_status(input int op, input int reply);
      int ack;
      if (op > 4) return 6;
      if (reply < 0) return 5;
      ack = int'(ack_tab.getc(op));
      if (reply == ack) return 0;
      if (reply == 8'h45) return 1;   // 'E'
      if (reply == 8'h30) return 2;   // '0'
      if (reply == 8'h58) return 3;   // 'X'
      return 4;
   endfunction

   // One command: rdy_pct<0 toggles i_out_ready each cycle; en_div>0 gives clk_en every en_div cycles
   task automatic do_cmd(input int op, input int reply, input int rdy_pct, input int en_div,
                         input int en_pct, input bit chk_lat, input string tag);
      logic [DW-1:0] got [$];
      int  len, en_cnt, wait_en, budget;
      bit  acc, fin, will_acc, in_wait, stall;
      logic [DW-1:0] stall_data;
      byte kc;
      len = exp_len(op);
      acc = 0; fin = 0; en_cnt = 0; wait_en = 0; stall = 0; stall_data = '0;
      cmd_op = op[2:0];
      cmd_valid = 1'b1;
      for (budget = 0; budget < 400 && !fin; budget++) begin
         if (stall) begin
            chk({tag, "_stall_valid"}, o_valid, 1);
            chk({tag, "_stall_data"}, o_data, stall_data);
         end
         in_wait = acc && (got.size() == len);
         if (en_div > 0) clk_en = (cyc % en_div) == 0;
         else            clk_en = ($urandom_range(99) < en_pct);
         if (rdy_pct < 0) i_out_ready = cyc[0];
         else             i_out_ready = ($urandom_range(99) < rdy_pct);
         i_valid = in_wait && (reply >= 0);
         i_data  = (reply >= 0) ? DW'(reply) : DW'($urandom_range(127));
         will_acc = !acc && clk_en && cmd_valid && cmd_ready;
         if (acc && clk_en) en_cnt++;
         if (in_wait && clk_en) wait_en++;
         if (acc && clk_en && o_valid && i_out_ready) got.push_back(o_data);
         stall = o_valid && !(clk_en && i_out_ready);
         stall_data = o_data;
         step();
         if (will_acc) begin
            acc = 1; en_cnt = 1; cmd_valid = 1'b0;
         end
         if (done) fin = 1;
      end
      cmd_valid = 1'b0;
      i_valid = 1'b0;
      chk({tag, "_done_seen"}, fin, 1);
      chk({tag, "_nchars"}, got.size(), len);
      for (int i = 0; i < len && i < got.size(); i++) begin
         kc = kw_tab[op][i];
         chk({tag, "_char"}, got[i], kc[DW-1:0]);
      end
      chk({tag, "_status"}, status, exp_status(op, reply));
      chk({tag, "_rsp"}, rsp_char, (op <= 4 && reply >= 0) ? reply : 0);
      if (op <= 4) chk({tag, "_wait_cycles"}, wait_en, (reply < 0) ? TO : 1);
      if (chk_lat) chk({tag, "_latency"}, en_cnt, (op > 4) ? 1 : len + 2);
      // done must last exactly one enabled cycle, then the block is idle again
      clk_en = 1'b1;
      step();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle_ready"}, cmd_ready, 1);
      $display("[TB] %s op=%0d reply=%0d chars=%0d status=%0d rsp=%0h", tag, op, reply, got.size(), status, rsp_char);
   endtask

   initial begin
      int  op, pick, reply;
      bit  saw_done;
      rst = 1'b1; clk_en = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
      i_out_ready = 1'b0; i_valid = 1'b0; i_data = '0;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_data", o_data, 0);
      chk("rst_o_in_ready", o_in_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      chk("rst_rsp", rsp_char, 0);
      $display("[TB] reset state checked");

      do_cmd(0, 8'h4E, 100, 1, 100, 1, "nop_ok");
      do_cmd(3, 8'h57, -1, 1, 100, 0, "write_toggle");
      do_cmd(4, 8'h45, 100, 1, 100, 1, "read_badcmd");
      do_cmd(4, 8'h5A, 100, 1, 100, 1, "read_unexp");
      do_cmd(1, -1, 100, 1, 100, 0, "boot_timeout");
      do_cmd(7, -1, 100, 1, 100, 1, "badop7");
      do_cmd(2, 8'h52, 100, 3, 0, 0, "rst_en_third");
      do_cmd(2, 8'h30, 100, 1, 100, 1, "rst_unknown");
      do_cmd(0, 8'h58, 100, 1, 100, 1, "nop_exception");

      // Reset in the middle of sending "boot": abort with no done pulse
      clk_en = 1'b1; i_out_ready = 1'b1; cmd_op = 3'd1; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      chk("midrst_sending", o_valid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_o_valid", o_valid, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_done", done, 0);
      saw_done = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done || o_valid) saw_done = 1;
      end
      chk("midrst_quiet", saw_done, 0);
      $display("[TB] mid-send reset checked");

      // Randomized traffic against the reference rules
      for (int n = 0; n < 24; n++) begin
         op = $urandom_range(7);
         pick = $urandom_range(5);
         case (pick)
            0: reply = (op <= 4) ? int'(ack_tab.getc(op)) : 8'h4E;
            1: reply = 8'h45;
            2: reply = 8'h30;
            3: reply = 8'h58;
            4: reply = $urandom_range(8'h21, 8'h7E);
            default: reply = -1;
         endcase
         do_cmd(op, reply, $urandom_range(40, 100), 0, $urandom_range(40, 100), 0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
